dram_responder: RTL and testbench

- Responder end of the core's DRAM access interface: holds the data RAM storage and answers core read/write requests with the fixed 1-cycle read latency the core's FSM expects.
- Adds a host port with valid/ready handshake, so a loader/debug agent can fill matrices before i_start and read results after o_busy falls.
- Arbitrates the two requesters onto a single-port storage array. The core has absolute priority and never stalls.

---
 rtl/mem_pkg.sv | 16 +
 rtl/dram_responder_if.sv | 33 +++
 rtl/sp_ram_sync.sv | 21 ++
 rtl/dram_responder.sv | 87 ++++++++
 tb/tb_dram_responder.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared widths, host FSM state type and the address range check for the DRAM responder.
// Addresses at or beyond the implemented depth are out of range; nothing aliases.
package mem_pkg;
    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 4096;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } host_state_e;

    function automatic logic addr_in_range(input logic [31:0] addr, input int depth);
        return addr < $unsigned(depth);
    endfunction
endpackage

// File: rtl/dram_responder_if.sv
// Core strobe port plus host valid/ready port of the DRAM responder, grouped as one bundle.
interface dram_responder_if
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic [ADDR_W-1:0] i_core_addr;
    logic              i_core_read;
    logic              i_core_write;
    logic [DATA_W-1:0] i_core_data;
    logic [DATA_W-1:0] o_core_q;
    logic              i_host_valid;
    logic              o_host_ready;
    logic              i_host_we;
    logic [ADDR_W-1:0] i_host_addr;
    logic [DATA_W-1:0] i_host_data;
    logic              o_host_rvalid;
    logic [DATA_W-1:0] o_host_rdata;
    logic              o_oob_err;

    modport master (
        output i_core_addr, i_core_read, i_core_write, i_core_data,
        output i_host_valid, i_host_we, i_host_addr, i_host_data,
        input  o_core_q, o_host_ready, o_host_rvalid, o_host_rdata, o_oob_err
    );

    modport slave (
        input  i_core_addr, i_core_read, i_core_write, i_core_data,
        input  i_host_valid, i_host_we, i_host_addr, i_host_data,
        output o_core_q, o_host_ready, o_host_rvalid, o_host_rdata, o_oob_err
    );
endinterface

// File: rtl/sp_ram_sync.sv
// Single-port synchronous RAM: 1-cycle read latency, read-before-write, array never reset.
module sp_ram_sync #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4096
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end
endmodule

// File: rtl/dram_responder.sv
// Arbitrates core (absolute priority, never stalls) and host (valid/ready) onto one RAM port.
// Core reads return next cycle; host reads answer with a 1-cycle rvalid pulse from RESP.
module dram_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    dram_responder_if.slave bus
);
    localparam int RAM_AW = $clog2(DEPTH);

    host_state_e       state, state_nxt;
    logic              core_strobe;
    logic              host_ready;
    logic              host_acc;
    logic              access;
    logic              addr_ok;
    logic [ADDR_W-1:0] addr_mux;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              core_rd_d;
    logic              oob_d;
    logic [DATA_W-1:0] core_q_hold;
    logic [DATA_W-1:0] core_q;
    logic              rvalid;

    assign core_strobe = bus.i_core_read | bus.i_core_write;
    assign host_ready  = !i_rst && !core_strobe && (state != RESP);
    assign host_acc    = bus.i_host_valid && host_ready;
    assign access      = core_strobe | host_acc;
    assign addr_mux    = core_strobe ? bus.i_core_addr : bus.i_host_addr;
    assign ram_wdata   = core_strobe ? bus.i_core_data : bus.i_host_data;
    assign addr_ok     = addr_in_range(32'(addr_mux), DEPTH);
    // Writes are suppressed while in reset so an in-flight core access is dropped.
    assign ram_we      = !i_rst && addr_ok &&
                         (core_strobe ? bus.i_core_write : (host_acc && bus.i_host_we));

    sp_ram_sync #(
        .ADDR_W (RAM_AW),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (i_clk),
        .addr  (addr_mux[RAM_AW-1:0]),
        .we    (ram_we),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (host_acc && !bus.i_host_we) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            core_rd_d   <= 1'b0;
            oob_d       <= 1'b0;
            core_q_hold <= '0;
        end else begin
            state       <= state_nxt;
            core_rd_d   <= bus.i_core_read;
            oob_d       <= access && !addr_ok;
            core_q_hold <= core_q;
        end
    end

    // The RAM output register is shared, so the core value is captured and held between reads.
    assign core_q = core_rd_d ? (oob_d ? '0 : ram_rdata) : core_q_hold;
    assign rvalid = !i_rst && (state == RESP);

    assign bus.o_core_q      = i_rst ? '0 : core_q;
    assign bus.o_host_ready  = host_ready;
    assign bus.o_host_rvalid = rvalid;
    assign bus.o_host_rdata  = (rvalid && !oob_d) ? ram_rdata : '0;
    assign bus.o_oob_err     = !i_rst && oob_d;
endmodule

// File: tb/tb_dram_responder.sv
// Directed table-driven bench for dram_responder plus hand sequences for collision and reset.
module tb_dram_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dram_responder_if #(.ADDR_W(16), .DATA_W(8)) bus ();

    dram_responder #(.ADDR_W(16), .DATA_W(8), .DEPTH(4096)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        logic        cr;
        logic        cw;
        logic [15:0] ca;
        logic [7:0]  cd;
        logic        hv;
        logic        hw;
        logic [15:0] ha;
        logic [7:0]  hd;
        logic        e_rdy;
        logic [7:0]  e_cq;
        logic        e_rv;
        logic [7:0]  e_rd;
        logic        e_oob;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.i_core_read  = v.cr;
        bus.i_core_write = v.cw;
        bus.i_core_addr  = v.ca;
        bus.i_core_data  = v.cd;
        bus.i_host_valid = v.hv;
        bus.i_host_we    = v.hw;
        bus.i_host_addr  = v.ha;
        bus.i_host_data  = v.hd;
    endtask

    task automatic chk_all(input string tag, input logic rdy, input logic [7:0] cq,
                           input logic rv, input logic [7:0] rd, input logic oob);
        chk({tag, ".ready"},  32'(bus.o_host_ready),  32'(rdy));
        chk({tag, ".core_q"}, 32'(bus.o_core_q),      32'(cq));
        chk({tag, ".rvalid"}, 32'(bus.o_host_rvalid), 32'(rv));
        chk({tag, ".rdata"},  32'(bus.o_host_rdata),  32'(rd));
        chk({tag, ".oob"},    32'(bus.o_oob_err),     32'(oob));
    endtask

    initial begin
        int waited;
        vec_t idle;

        //            cr cw  ca       cd     hv hw ha       hd     rdy cq     rv rd     oob
        idle     = '{0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 8'h00, 0};
        tbl[0]   = '{0, 0, 16'h0000, 8'h00, 1, 1, 16'h0005, 8'h12, 1, 8'h00, 0, 8'h00, 0};
        tbl[1]   = '{0, 0, 16'h0000, 8'h00, 1, 0, 16'h0005, 8'h00, 1, 8'h00, 0, 8'h00, 0};
        tbl[2]   = '{0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 8'h00, 1, 8'h12, 0};
        tbl[3]   = '{0, 1, 16'h0010, 8'hA5, 0, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 8'h00, 0};
        tbl[4]   = '{1, 0, 16'h0010, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 8'h00, 0, 8'h00, 0};
        tbl[5]   = '{1, 1, 16'h0010, 8'h3C, 0, 0, 16'h0000, 8'h00, 0, 8'hA5, 0, 8'h00, 0};
        tbl[6]   = '{1, 0, 16'h0010, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 8'hA5, 0, 8'h00, 0};
        tbl[7]   = '{0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, 1, 8'h3C, 0, 8'h00, 0};
        tbl[8]   = '{0, 0, 16'h0000, 8'h00, 1, 1, 16'h0000, 8'h55, 1, 8'h3C, 0, 8'h00, 0};
        tbl[9]   = '{0, 0, 16'h0000, 8'h00, 1, 1, 16'h1000, 8'h77, 1, 8'h3C, 0, 8'h00, 0};
        tbl[10]  = '{0, 0, 16'h0000, 8'h00, 1, 0, 16'h1000, 8'h00, 1, 8'h3C, 0, 8'h00, 1};
        tbl[11]  = '{0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 8'h3C, 1, 8'h00, 1};
        tbl[12]  = '{0, 0, 16'h0000, 8'h00, 1, 0, 16'h0000, 8'h00, 1, 8'h3C, 0, 8'h00, 0};
        tbl[13]  = '{0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 8'h3C, 1, 8'h55, 0};
        tbl[14]  = '{1, 0, 16'h2000, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 8'h3C, 0, 8'h00, 0};
        tbl[15]  = '{0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, 1, 8'h00, 0, 8'h00, 1};
        tbl[16]  = '{0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, 1, 8'h00, 0, 8'h00, 0};

        drive(idle);
        bus.i_host_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all("reset", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(idle);

        for (int i = 0; i < 17; i++) begin
            @(posedge clk);
            #1;
            drive(tbl[i]);
            @(negedge clk);
            chk_all($sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_cq,
                    tbl[i].e_rv, tbl[i].e_rd, tbl[i].e_oob);
        end

        // Host write held while the core streams five reads.
        @(posedge clk);
        #1;
        drive(idle);
        bus.i_host_valid = 1'b1;
        bus.i_host_we    = 1'b1;
        bus.i_host_addr  = 16'h0020;
        bus.i_host_data  = 8'h9A;
        bus.i_core_addr  = 16'h0010;
        for (int k = 0; k < 5; k++) begin
            bus.i_core_read = 1'b1;
            @(negedge clk);
            chk($sformatf("collide%0d.ready", k), 32'(bus.o_host_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        bus.i_core_read = 1'b0;
        @(negedge clk);
        chk("collide.core_q", 32'(bus.o_core_q), 32'h3C);
        waited = 0;
        while (!bus.o_host_ready && waited < 4) begin
            @(posedge clk);
            #1;
            waited++;
            @(negedge clk);
        end
        chk("collide.wait_cycles", 32'(waited), 32'd0);
        @(posedge clk);
        #1;
        bus.i_host_we = 1'b0;
        @(negedge clk);
        chk("collide.rd_ready", 32'(bus.o_host_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.i_host_valid = 1'b0;
        @(negedge clk);
        chk("collide.rvalid", 32'(bus.o_host_rvalid), 32'd1);
        chk("collide.rdata",  32'(bus.o_host_rdata),  32'h9A);

        // Reset arriving in the cycle the host read would respond.
        @(posedge clk);
        #1;
        bus.i_host_valid = 1'b1;
        bus.i_host_addr  = 16'h0005;
        @(negedge clk);
        chk("rst.accept", 32'(bus.o_host_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.i_host_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk_all("rst.during", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_all("rst.after", 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
